// File: rtl/butterfly_pkg.sv
// Shared step encoding, capture slots and sequencer states for the butterfly press sequencer.
package butterfly_pkg;

  typedef enum logic [3:0] {
    ST_LD_W, ST_LD_B, ST_C_REWB, ST_C_IMY, ST_C_IMZ, ST_LD_A, ST_C_REZ2,
    ST_C_REZ, ST_C_REY, ST_D_REY, ST_D_IMY, ST_D_REZ, ST_D_IMZ, ST_CLR
  } step_e;

  localparam step_e LD_W = ST_LD_W;
  localparam step_e LD_B = ST_LD_B;
  localparam step_e LD_A = ST_LD_A;

  localparam int SLOT_REY = 0;
  localparam int SLOT_IMY = 1;
  localparam int SLOT_REZ = 2;
  localparam int SLOT_IMZ = 3;

  localparam logic [1:0] OP_W = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_A = 2'd2;

  typedef enum logic [1:0] {IDLE, GAP, PRESS} seq_state_e;

  // A display value is captured in the gap that follows its display press.
  function automatic logic is_capture_step(step_e s);
    return (s >= ST_D_IMY);
  endfunction

  function automatic logic [1:0] capture_slot(step_e s);
    return 2'(s - ST_D_IMY);
  endfunction

endpackage

// File: rtl/butterfly_sequencer_press_timer.sv
// Down-counter timing one GAP or PRESS phase; expire is high on the last cycle of the phase.
module press_timer #(
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/butterfly_sequencer.sv
// Drives the butterfly core's 14-press ReadyIn sequence per operand set and collects its displayed results.
module butterfly_sequencer
  import butterfly_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NUM_OPS      = 4,
  parameter int PRESS_CYCLES = 16,
  parameter int GAP_CYCLES   = 16,
  localparam int IDX_W       = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                start,
  input  logic                op_we,
  input  logic [IDX_W-1:0]    op_idx,
  input  logic [1:0]          op_sel,
  input  logic [DATA_W-1:0]   op_wdata,
  output logic                ready_out,
  output logic [DATA_W-1:0]   data_out,
  input  logic [DATA_W-1:0]   result_in,
  output logic                res_valid,
  output logic [IDX_W-1:0]    res_idx,
  output logic [4*DATA_W-1:0] res_word,
  output logic                busy,
  output logic                done
);

  localparam int MAX_C = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  seq_state_e       state;
  step_e            step;
  logic [IDX_W-1:0] set_idx;
  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_expire;
  logic             gap_last;

  logic [DATA_W-1:0] mem_w [NUM_OPS];
  logic [DATA_W-1:0] mem_b [NUM_OPS];
  logic [DATA_W-1:0] mem_a [NUM_OPS];
  logic [DATA_W-1:0] cap   [3];

  function automatic logic [DATA_W-1:0] operand(step_e s, logic [IDX_W-1:0] i);
    case (s)
      LD_W:    return mem_w[i];
      LD_B:    return mem_b[i];
      LD_A:    return mem_a[i];
      default: return '0;
    endcase
  endfunction

  // The timer reloads on every phase change; IDLE only loads it on start.
  assign t_load   = (state == IDLE) ? start : t_expire;
  assign t_val    = (state == GAP) ? CNT_W'(PRESS_CYCLES - 1) : CNT_W'(GAP_CYCLES - 1);
  assign gap_last = (state == GAP) && t_expire;

  press_timer #(.CNT_W(CNT_W)) u_timer (
    .Clock    (Clock),
    .nReset   (nReset),
    .load     (t_load),
    .load_val (t_val),
    .expire   (t_expire)
  );

  // Operand memory and capture buffer are pure data and carry no reset.
  always_ff @(posedge Clock) begin
    if (op_we && !busy) begin
      case (op_sel)
        OP_W:    mem_w[op_idx] <= op_wdata;
        OP_B:    mem_b[op_idx] <= op_wdata;
        OP_A:    mem_a[op_idx] <= op_wdata;
        default: ;
      endcase
    end
    if (gap_last && is_capture_step(step) && (step != ST_CLR)) begin
      cap[capture_slot(step)] <= result_in;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      step      <= ST_LD_W;
      set_idx   <= '0;
      ready_out <= 1'b0;
      data_out  <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_word  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= GAP;
            step     <= ST_LD_W;
            set_idx  <= '0;
            busy     <= 1'b1;
            data_out <= operand(ST_LD_W, '0);
          end
        end
        GAP: begin
          if (t_expire) begin
            state     <= PRESS;
            ready_out <= 1'b1;
            if (step == ST_CLR) begin
              res_valid <= 1'b1;
              res_idx   <= set_idx;
              res_word  <= {cap[SLOT_REY], cap[SLOT_IMY], cap[SLOT_REZ], result_in};
            end
          end
        end
        PRESS: begin
          if (t_expire) begin
            ready_out <= 1'b0;
            if (step != ST_CLR) begin
              state    <= GAP;
              step     <= step_e'(step + 4'd1);
              data_out <= operand(step_e'(step + 4'd1), set_idx);
            end else if (set_idx != IDX_W'(NUM_OPS - 1)) begin
              state    <= GAP;
              step     <= ST_LD_W;
              set_idx  <= set_idx + 1'b1;
              data_out <= operand(ST_LD_W, set_idx + 1'b1);
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              data_out <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_butterfly_sequencer.sv
// Directed bench for butterfly_sequencer with a stub butterfly answering on the display steps.
module tb_butterfly_sequencer;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        start;
  logic        op_we;
  logic [1:0]  op_idx;
  logic [1:0]  op_sel;
  logic [7:0]  op_wdata;
  logic        ready_out;
  logic [7:0]  data_out;
  logic [7:0]  result_in;
  logic        res_valid;
  logic [1:0]  res_idx;
  logic [31:0] res_word;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  butterfly_sequencer #(
    .DATA_W(8), .NUM_OPS(4), .PRESS_CYCLES(16), .GAP_CYCLES(16)
  ) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .start     (start),
    .op_we     (op_we),
    .op_idx    (op_idx),
    .op_sel    (op_sel),
    .op_wdata  (op_wdata),
    .ready_out (ready_out),
    .data_out  (data_out),
    .result_in (result_in),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .res_word  (res_word),
    .busy      (busy),
    .done      (done)
  );

  always #5 Clock = ~Clock;

  // Observation state, sampled on the falling edge.
  int          cyc = 0;
  int          np, hi_len, lo_len, hi_min, hi_max, lo_min, lo_max;
  int          nrv, ndone, done_err;
  logic        ready_q;
  logic [7:0]  press_data [64];
  logic [7:0]  press_end  [64];
  logic [1:0]  rv_idx     [8];
  logic [31:0] rv_word    [8];
  int          rv_cyc     [8];

  // Stub butterfly: after n completed presses, presses 10..13 of a set show ReY, ImY, ReZ, ImZ.
  function automatic logic [7:0] stub(int n);
    int k;
    int s;
    k = n % 14;
    s = n / 14;
    if (k >= 10) return 8'(8'h11 * (k - 9) + 8'h10 * s);
    return 8'hEE;
  endfunction

  assign result_in = stub(np);

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (start && !busy) begin
      np <= 0; hi_len <= 0; lo_len <= 0;
      hi_min <= 9999; hi_max <= 0; lo_min <= 9999; lo_max <= 0;
      nrv <= 0; ndone <= 0; done_err <= 0;
    end else begin
      if (ready_out && !ready_q) begin
        press_data[np[5:0]] <= data_out;
        lo_min <= (lo_len < lo_min) ? lo_len : lo_min;
        lo_max <= (lo_len > lo_max) ? lo_len : lo_max;
        lo_len <= 0;
        hi_len <= 1;
      end else if (ready_out) begin
        hi_len <= hi_len + 1;
      end
      if (ready_out) press_end[np[5:0]] <= data_out;
      if (!ready_out && ready_q) begin
        np     <= np + 1;
        hi_min <= (hi_len < hi_min) ? hi_len : hi_min;
        hi_max <= (hi_len > hi_max) ? hi_len : hi_max;
      end
      if (busy && !ready_out) lo_len <= (ready_q ? 0 : lo_len) + 1;
      if (res_valid) begin
        rv_idx[nrv[2:0]]  <= res_idx;
        rv_word[nrv[2:0]] <= res_word;
        rv_cyc[nrv[2:0]]  <= cyc;
        nrv <= nrv + 1;
      end
      if (done) begin
        ndone <= ndone + 1;
        if (busy || ready_out) done_err <= done_err + 1;
      end
    end
    ready_q <= ready_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic write_op(input logic [1:0] idx, input logic [1:0] sel, input logic [7:0] val);
    op_we = 1'b1; op_idx = idx; op_sel = sel; op_wdata = val;
    tick();
    op_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_word [4];
    logic [7:0]  exp_d;
    int          errs;
    exp_word[0] = 32'h11223344;
    exp_word[1] = 32'h21324354;
    exp_word[2] = 32'h31425364;
    exp_word[3] = 32'h41526374;

    // Reset held, start pulsed meanwhile.
    nReset = 1'b0; start = 1'b1; op_we = 1'b0; op_idx = '0; op_sel = '0; op_wdata = '0;
    repeat (3) tick();
    check("rst_ready_out", ready_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_idx", res_idx, 0);
    check("rst_res_word", res_word, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    start = 1'b0;
    tick();
    nReset = 1'b1;
    repeat (5) tick();
    check("idle_busy", busy, 0);
    check("idle_ready_out", ready_out, 0);

    // Operands: set s gets W=0x40+s, B=0x10+s, A=0x20+s; op_sel=3 must be dropped.
    for (int s = 0; s < 4; s++) begin
      write_op(2'(s), 2'd0, 8'(8'h40 + s));
      write_op(2'(s), 2'd1, 8'(8'h10 + s));
      write_op(2'(s), 2'd2, 8'(8'h20 + s));
    end
    write_op(2'd0, 2'd3, 8'h99);

    // Full four-set run with a write and a second start issued mid-run.
    pulse_start();
    repeat (100) tick();
    check("busy_mid_run", busy, 1);
    op_we = 1'b1; op_idx = 2'd1; op_sel = 2'd0; op_wdata = 8'hFF; start = 1'b1;
    tick();
    op_we = 1'b0; start = 1'b0;
    for (int i = 0; i < 4000 && ndone == 0; i++) tick();
    repeat (5) tick();
    check("done_count", ndone, 1);
    check("done_with_busy_low", done_err, 0);
    check("busy_after_done", busy, 0);
    check("press_count", np, 56);
    check("press_hi_min", hi_min, 16);
    check("press_hi_max", hi_max, 16);
    check("gap_lo_min", lo_min, 16);
    check("gap_lo_max", lo_max, 16);
    errs = 0;
    for (int p = 0; p < 56; p++) begin
      case (p % 14)
        0:       exp_d = 8'(8'h40 + p / 14);
        1:       exp_d = 8'(8'h10 + p / 14);
        5:       exp_d = 8'(8'h20 + p / 14);
        default: exp_d = 8'h00;
      endcase
      if (press_data[p] !== exp_d || press_end[p] !== exp_d) errs++;
    end
    check("data_out_pattern_errs", errs, 0);
    check("data_step0_set0", press_data[0], 8'h40);
    check("data_step1_set0", press_data[1], 8'h10);
    check("data_step5_set0", press_data[5], 8'h20);
    check("data_step2_set0", press_data[2], 8'h00);
    check("data_step0_set1_unchanged", press_data[14], 8'h41);
    check("res_valid_count", nrv, 4);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("res_idx_%0d", s), rv_idx[s], 32'(s));
      check($sformatf("res_word_%0d", s), rv_word[s], exp_word[s]);
    end
    for (int s = 1; s < 4; s++) check($sformatf("res_spacing_%0d", s), rv_cyc[s] - rv_cyc[s-1], 448);
    check("res_word_hold", res_word, 32'h41526374);

    // Asynchronous reset in the middle of step 6's press, then a clean restart.
    pulse_start();
    for (int i = 0; i < 1000 && !(np == 6 && ready_out); i++) tick();
    repeat (3) tick();
    check("step6_press_active", ready_out, 1);
    check("step6_press_index", np, 6);
    #2 nReset = 1'b0;
    #1;
    check("async_rst_ready_out", ready_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_res_word", res_word, 0);
    tick();
    tick();
    nReset = 1'b1;
    tick();
    pulse_start();
    for (int i = 0; i < 1000 && np < 2; i++) tick();
    check("restart_press_count", np, 2);
    check("restart_step0", press_data[0], 8'h40);
    check("restart_step1", press_data[1], 8'h10);
    check("restart_busy", busy, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
